qmax_updater: RTL and testbench

- Read-modify-write front end that keeps the per-state Q-max BRAM current.
- Takes a stream of (state, new Q value) pairs from the Q-update datapath and reads the stored max for that state from the Q-max table.
- Writes back max(stored, new) and reports the result downstream.
- Owns table initialisation: after reset, and on request, it sweeps the table to zero.

---
 rtl/qmax_updater.sv | 200 ++++++++++++++++++++
 tb/tb_qmax_updater.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmax_updater.sv
// Read-modify-write updater that keeps the per-state Q-max table current and owns its zero sweep.
// Optional statistics counters are enabled by defining QMAX_UPDATER_STATS_EN.
`timescale 1ns/1ps
module qmax_updater #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_state,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic                  o_read_en,
  output logic [ADDR_WIDTH-1:0] o_addr_r,
  input  logic [DATA_WIDTH-1:0] i_qmax_rd,
  output logic                  o_write_en,
  output logic [ADDR_WIDTH-1:0] o_addr_w,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_upd_valid,
  output logic [ADDR_WIDTH-1:0] o_upd_state,
  output logic [DATA_WIDTH-1:0] o_upd_qmax,
  output logic                  o_upd_changed,
`ifdef QMAX_UPDATER_STATS_EN
  output logic [31:0]           o_stat_updates,
  output logic [31:0]           o_stat_raises,
`endif
  output logic                  o_busy
);

  localparam int unsigned STAT_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;
  logic                    clear_entry;

  logic                    s1_valid;
  logic [ADDR_WIDTH-1:0]   s1_state;
  logic [DATA_WIDTH-1:0]   s1_q;

  logic                    fwd_valid;
  logic [ADDR_WIDTH-1:0]   fwd_state;
  logic [DATA_WIDTH-1:0]   fwd_val;

  logic [DATA_WIDTH-1:0]   old_val;
  logic [DATA_WIDTH-1:0]   new_max;
  logic                    raise;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
      ST_RUN:   if (i_clear) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign clear_entry = (state_q != ST_CLEAR) && (state_d == ST_CLEAR);

  // Stage-1 compare; a write issued last cycle is not yet visible in the read data
  always_comb begin
    old_val = i_qmax_rd;
    if (fwd_valid && (fwd_state == s1_state)) begin
      old_val = fwd_val;
    end
    new_max = (s1_q > old_val) ? s1_q : old_val;
    raise   = i_rst_n && s1_valid && (s1_q > old_val);
  end

  // Output logic; enables are held off while reset is asserted
  always_comb begin
    o_ready    = 1'b0;
    o_busy     = 1'b1;
    o_read_en  = 1'b0;
    o_addr_r   = i_state;
    o_write_en = 1'b0;
    o_addr_w   = s1_state;
    o_data     = s1_q;
    case (state_q)
      ST_CLEAR: begin
        o_write_en = i_rst_n;
        o_addr_w   = clr_cnt_q;
        o_data     = '0;
      end
      ST_RUN: begin
        o_busy     = 1'b0;
        o_ready    = i_rst_n && !i_clear;
        o_read_en  = i_rst_n && i_valid && !i_clear;
        o_write_en = raise;
      end
      ST_FLUSH: begin
        o_write_en = raise;
      end
      default: begin
        o_busy = 1'b1;
      end
    endcase
  end

  // Sweep address counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + ADDR_WIDTH'(1);
    end
  end

  // Stage-1 pair register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_state <= '0;
      s1_q     <= '0;
    end else begin
      s1_valid <= o_read_en;
      if (o_read_en) begin
        s1_state <= i_state;
        s1_q     <= i_q;
      end
    end
  end

  // Forward register covers the read issued in the same cycle as a write
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fwd_valid <= 1'b0;
      fwd_state <= '0;
      fwd_val   <= '0;
    end else begin
      fwd_valid <= s1_valid && !clear_entry;
      if (s1_valid) begin
        fwd_state <= s1_state;
        fwd_val   <= new_max;
      end
    end
  end

  // Registered result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_upd_valid   <= 1'b0;
      o_upd_state   <= '0;
      o_upd_qmax    <= '0;
      o_upd_changed <= 1'b0;
    end else begin
      o_upd_valid   <= s1_valid;
      o_upd_changed <= raise;
      if (s1_valid) begin
        o_upd_state <= s1_state;
        o_upd_qmax  <= new_max;
      end
    end
  end

`ifdef QMAX_UPDATER_STATS_EN
  logic [STAT_WIDTH-1:0] stat_updates_q;
  logic [STAT_WIDTH-1:0] stat_raises_q;

  // Saturating counters, counted on the edge that loads the result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || clear_entry) begin
      stat_updates_q <= '0;
      stat_raises_q  <= '0;
    end else begin
      if (s1_valid && (stat_updates_q != '1)) begin
        stat_updates_q <= stat_updates_q + STAT_WIDTH'(1);
      end
      if (raise && (stat_raises_q != '1)) begin
        stat_raises_q <= stat_raises_q + STAT_WIDTH'(1);
      end
    end
  end

  assign o_stat_updates = stat_updates_q;
  assign o_stat_raises  = stat_raises_q;
`endif

endmodule

// File: tb/tb_qmax_updater.sv
// Bench for qmax_updater: directed cycle table, hand sequences, random pairs against a per-state max model.
`timescale 1ns/1ps
module tb_qmax_updater;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 64;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          clear    = 1'b0;
  logic          valid    = 1'b0;
  logic [AW-1:0] state    = '0;
  logic [DW-1:0] q        = '0;
  logic          scramble = 1'b1;
  logic          ready, read_en, write_en, upd_valid, upd_changed, busy;
  logic [AW-1:0] addr_r, addr_w, upd_state;
  logic [DW-1:0] qmax_rd, data, upd_qmax;
  logic [DW-1:0] mem [DEPTH];
`ifdef QMAX_UPDATER_STATS_EN
  logic [31:0]   stat_updates, stat_raises;
`endif

  int total = 0;
  int bad   = 0;

  qmax_updater #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_clear(clear),
    .i_valid(valid),
    .o_ready(ready),
    .i_state(state),
    .i_q(q),
    .o_read_en(read_en),
    .o_addr_r(addr_r),
    .i_qmax_rd(qmax_rd),
    .o_write_en(write_en),
    .o_addr_w(addr_w),
    .o_data(data),
    .o_upd_valid(upd_valid),
    .o_upd_state(upd_state),
    .o_upd_qmax(upd_qmax),
    .o_upd_changed(upd_changed),
`ifdef QMAX_UPDATER_STATS_EN
    .o_stat_updates(stat_updates),
    .o_stat_raises(stat_raises),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Read-first synchronous table model; starts filled with junk so the sweep is observable
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom_range(1, 255));
    end else begin
      if (read_en)  qmax_rd <= mem[addr_r];
      if (write_en) mem[addr_w] <= data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int v; int s; int qq; int clr;
    int rdy; int ren; int bsy;
    int we; int aw; int wd;
    int uv; int us; int uq; int uc;
  } vec_t;

  typedef struct {
    bit v; int s; int q; int mx; bit chg;
  } exp_t;

  vec_t vt[17];
  int   ref_max[DEPTH];

  function automatic vec_t mk(input int v, s, qq, clr, rdy, ren, bsy,
                              we, aw, wd, uv, us, uq, uc);
    vec_t r;
    r.v = v; r.s = s; r.qq = qq; r.clr = clr;
    r.rdy = rdy; r.ren = ren; r.bsy = bsy;
    r.we = we; r.aw = aw; r.wd = wd;
    r.uv = uv; r.us = us; r.uq = uq; r.uc = uc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expects to be entered at the first sweep cycle (address 0)
  task automatic check_sweep(input string tag);
    int nz;
    for (int c = 0; c < int'(DEPTH); c++) begin
      @(negedge clk);
      chk({tag, " busy"},  32'(busy), 32'(1));
      chk({tag, " ready"}, 32'(ready), 32'(0));
      chk({tag, " we"},    32'(write_en), 32'(1));
      chk({tag, " aw"},    32'(addr_w), 32'(c));
      chk({tag, " wd"},    32'(data), 32'(0));
      next_cycle();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk({tag, " run busy"},  32'(busy), 32'(0));
      chk({tag, " run ready"}, 32'(ready), 32'(1));
      chk({tag, " run we"},    32'(write_en), 32'(0));
      next_cycle();
    end
    nz = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== '0) nz++;
    chk({tag, " table zero"}, 32'(nz), 32'(0));
  endtask

  initial begin
    exp_t cur, e1, e2;
    int   mism;

    // Reset, then the power-on sweep
    next_cycle();
    scramble = 1'b0;
    @(negedge clk);
    chk("rst upd_valid", 32'(upd_valid), 32'(0));
    chk("rst upd_state", 32'(upd_state), 32'(0));
    chk("rst upd_qmax",  32'(upd_qmax), 32'(0));
    chk("rst changed",   32'(upd_changed), 32'(0));
    chk("rst read_en",   32'(read_en), 32'(0));
    chk("rst write_en",  32'(write_en), 32'(0));
`ifdef QMAX_UPDATER_STATS_EN
    chk("rst stat_updates", stat_updates, 32'(0));
    chk("rst stat_raises",  stat_raises, 32'(0));
`endif
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    check_sweep("init");

    // Directed cycle table: single pair, same-state forwarding, equal values, clear with stage 1 busy
    vt[0]  = mk(1, 5, 'h20, 0,  1, 1, 0,  0, 0, 0,      0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0,    0,  1, 0, 0,  1, 5, 'h20,   0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0,    0,  1, 0, 0,  0, 0, 0,      1, 5, 'h20, 1);
    vt[3]  = mk(1, 7, 'h30, 0,  1, 1, 0,  0, 0, 0,      0, 0, 0, 0);
    vt[4]  = mk(1, 7, 'h10, 0,  1, 1, 0,  1, 7, 'h30,   0, 0, 0, 0);
    vt[5]  = mk(1, 7, 'h40, 0,  1, 1, 0,  0, 0, 0,      1, 7, 'h30, 1);
    vt[6]  = mk(0, 0, 0,    0,  1, 0, 0,  1, 7, 'h40,   1, 7, 'h30, 0);
    vt[7]  = mk(0, 0, 0,    0,  1, 0, 0,  0, 0, 0,      1, 7, 'h40, 1);
    vt[8]  = mk(1, 3, 'h50, 0,  1, 1, 0,  0, 0, 0,      0, 0, 0, 0);
    vt[9]  = mk(1, 4, 'h50, 0,  1, 1, 0,  1, 3, 'h50,   0, 0, 0, 0);
    vt[10] = mk(1, 3, 'h50, 0,  1, 1, 0,  1, 4, 'h50,   1, 3, 'h50, 1);
    vt[11] = mk(0, 0, 0,    0,  1, 0, 0,  0, 0, 0,      1, 4, 'h50, 1);
    vt[12] = mk(0, 0, 0,    0,  1, 0, 0,  0, 0, 0,      1, 3, 'h50, 0);
    vt[13] = mk(0, 0, 0,    0,  1, 0, 0,  0, 0, 0,      0, 0, 0, 0);
    vt[14] = mk(1, 9, 'h60, 0,  1, 1, 0,  0, 0, 0,      0, 0, 0, 0);
    vt[15] = mk(1, 10, 'h11, 1, 0, 0, 0,  1, 9, 'h60,   0, 0, 0, 0);
    vt[16] = mk(1, 11, 'h22, 1, 0, 0, 1,  0, 0, 0,      1, 9, 'h60, 1);

    for (int i = 0; i < 17; i++) begin
      valid = 1'(vt[i].v);
      state = AW'(vt[i].s);
      q     = DW'(vt[i].qq);
      clear = 1'(vt[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d ready", i),   32'(ready), 32'(vt[i].rdy));
      chk($sformatf("vec%0d read_en", i), 32'(read_en), 32'(vt[i].ren));
      chk($sformatf("vec%0d busy", i),    32'(busy), 32'(vt[i].bsy));
      if (vt[i].ren != 0) chk($sformatf("vec%0d addr_r", i), 32'(addr_r), 32'(vt[i].s));
      chk($sformatf("vec%0d write_en", i), 32'(write_en), 32'(vt[i].we));
      if (vt[i].we != 0) begin
        chk($sformatf("vec%0d addr_w", i), 32'(addr_w), 32'(vt[i].aw));
        chk($sformatf("vec%0d data", i),   32'(data), 32'(vt[i].wd));
      end
      chk($sformatf("vec%0d upd_valid", i), 32'(upd_valid), 32'(vt[i].uv));
      if (vt[i].uv != 0) begin
        chk($sformatf("vec%0d upd_state", i),   32'(upd_state), 32'(vt[i].us));
        chk($sformatf("vec%0d upd_qmax", i),    32'(upd_qmax), 32'(vt[i].uq));
        chk($sformatf("vec%0d upd_changed", i), 32'(upd_changed), 32'(vt[i].uc));
      end
`ifdef QMAX_UPDATER_STATS_EN
      if (i == 13) begin
        chk("stat_updates after table", stat_updates, 32'(7));
        chk("stat_raises after table",  stat_raises, 32'(5));
      end
`endif
      next_cycle();
    end
    valid = 1'b0;
    clear = 1'b0;
    check_sweep("clear");
`ifdef QMAX_UPDATER_STATS_EN
    chk("stat_updates after clear", stat_updates, 32'(0));
    chk("stat_raises after clear",  stat_raises, 32'(0));
`endif

    // The state written just before the clear now reads back as zero
    valid = 1'b1; state = AW'(9); q = DW'(0);
    next_cycle();
    state = AW'(9); q = DW'(5);
    @(negedge clk);
    chk("post-clear q0 no write", 32'(write_en), 32'(0));
    next_cycle();
    valid = 1'b0;
    @(negedge clk);
    chk("post-clear uv",      32'(upd_valid), 32'(1));
    chk("post-clear qmax",    32'(upd_qmax), 32'(0));
    chk("post-clear changed", 32'(upd_changed), 32'(0));
    chk("post-clear q5 we",   32'(write_en), 32'(1));
    chk("post-clear q5 wd",   32'(data), 32'(5));
    next_cycle();
    @(negedge clk);
    chk("post-clear q5 qmax",    32'(upd_qmax), 32'(5));
    chk("post-clear q5 changed", 32'(upd_changed), 32'(1));
    next_cycle();

    // Random pairs against a per-state running maximum
    for (int i = 0; i < int'(DEPTH); i++) ref_max[i] = 0;
    ref_max[9] = 5;
    e1 = '{default: 0};
    e2 = '{default: 0};
    for (int n = 0; n < 1502; n++) begin
      cur = '{default: 0};
      cur.v = (n < 1500) && ($urandom_range(0, 3) != 0);
      cur.s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 63));
      cur.q = int'($urandom_range(0, 255));
      valid = cur.v;
      state = AW'(cur.s);
      q     = DW'(cur.q);
      if (cur.v) begin
        cur.chg = cur.q > ref_max[cur.s];
        cur.mx  = cur.chg ? cur.q : ref_max[cur.s];
        ref_max[cur.s] = cur.mx;
      end
      @(negedge clk);
      chk("rnd ready",   32'(ready), 32'(1));
      chk("rnd read_en", 32'(read_en), 32'(cur.v));
      if (cur.v) chk("rnd addr_r", 32'(addr_r), 32'(cur.s));
      chk("rnd write_en", 32'(write_en), 32'(e1.v && e1.chg));
      if (e1.v && e1.chg) begin
        chk("rnd addr_w", 32'(addr_w), 32'(e1.s));
        chk("rnd data",   32'(data), 32'(e1.q));
      end
      chk("rnd upd_valid", 32'(upd_valid), 32'(e2.v));
      if (e2.v) begin
        chk("rnd upd_state",   32'(upd_state), 32'(e2.s));
        chk("rnd upd_qmax",    32'(upd_qmax), 32'(e2.mx));
        chk("rnd upd_changed", 32'(upd_changed), 32'(e2.chg));
      end
      e2 = e1;
      e1 = cur;
      next_cycle();
    end
    mism = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (int'(mem[i]) != ref_max[i]) mism++;
    chk("rnd table contents", 32'(mism), 32'(0));

    // Reset in the middle of a sweep restarts it from address 0
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    next_cycle();
    for (int c = 0; c < 20; c++) next_cycle();
    @(negedge clk);
    chk("mid-sweep addr before reset", 32'(addr_w), 32'(20));
    rst_n = 1'b0;
    #1;
    chk("mid-sweep reset no write", 32'(write_en), 32'(0));
    next_cycle();
    rst_n = 1'b1;
    check_sweep("restart");
    chk("restart upd_valid", 32'(upd_valid), 32'(0));
`ifdef QMAX_UPDATER_STATS_EN
    chk("restart stat_updates", stat_updates, 32'(0));
    chk("restart stat_raises",  stat_raises, 32'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
